mmio_uart_tx: RTL

//  Memory-mapped 8N1 UART transmitter on single_cycle_cpu's data port (data_addr/data_wdata/data_wenable/data_rdata).

---
 rtl/mmio_uart_tx.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the CPU data port.
// A 16-byte register window holds TXDATA, STATUS, DIVISOR and CTRL.
// Bytes stored to TXDATA wait in a small FIFO until the serialiser sends them.
// Optional feature macro: UART_TX_IRQ_EN adds the irq output and CTRL.irq_en.
//
// Bus handshake: there is no valid/ready pair. A write is accepted on every
// posedge where the window is selected and wenable[0] is high. Reads are
// combinational and have no side effects. A store that finds the FIFO full
// is dropped and sets the sticky STATUS.ovf flag.
module mmio_uart_tx #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CLK_DIV    = 16'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  // Word offsets inside the window
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Bus decode
  logic sel;
  logic wr_en;
  logic wr_txdata;
  logic wr_status;
  logic wr_div;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  // Status and configuration registers
  logic          ovf;
  logic [15:0]   divisor;
  logic [15:0]   bit_len;
  logic [15:0]   reload;

  // Serialiser state; state is a plain named register so checkers can bind to it
  state_t        state;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done;
  logic          busy;

  // Bits of the bus that this block never looks at
  logic          unused_bits;

  assign sel       = (addr[31:4] == ADDR_BASE[31:4]);
  assign wr_en     = sel && wenable[0];
  assign wr_txdata = wr_en && (addr[3:2] == REG_TXDATA);
  assign wr_status = wr_en && (addr[3:2] == REG_STATUS);
  assign wr_div    = wr_en && (addr[3:2] == REG_DIVISOR);

  assign unused_bits = ^{wdata[31:16], addr[1:0], wenable[3:1]};

  // Flags come from the count before the edge, so a push in the same cycle
  // as a pop still sees the FIFO as full and is dropped.
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign push  = wr_txdata && !full;
  assign pop   = (state == IDLE) && !empty;

  // A divisor of zero would mean zero-length bits; treat it as one cycle.
  assign bit_len  = (divisor == 16'd0) ? 16'd1 : divisor;
  assign reload   = bit_len - 16'd1;
  assign bit_done = (baud_cnt == 16'd0);

  assign busy = (state != IDLE) || !empty;

  // Next FIFO occupancy; push and pop together leave it unchanged
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage is data-only and needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wdata[7:0];
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  // Sticky overflow flag, cleared by writing 1 to STATUS bit 3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (wr_txdata && full) begin
      ovf <= 1'b1;
    end else if (wr_status && wdata[3]) begin
      ovf <= 1'b0;
    end
  end

  // Baud divisor register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= CLK_DIV;
    end else if (wr_div) begin
      divisor <= wdata[15:0];
    end
  end

  // Serialiser FSM: each bit reloads the baud counter from the live divisor,
  // so a divisor write lands on the next bit boundary. tx is registered and
  // changes on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shreg    <= fifo_mem[rd_ptr];
            baud_cnt <= reload;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_idx  <= 3'd0;
            tx       <= shreg[0];
            baud_cnt <= reload;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= reload;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          // Returning to IDLE costs one clock before the next START
          if (bit_done) begin
            state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;
  logic wr_ctrl;
  logic active_next;
  logic busy_next;

  assign wr_ctrl = wr_en && (addr[3:2] == REG_CTRL);

  // The FSM is active after this edge unless it is idle with nothing queued
  // or it is finishing the final stop-bit cycle.
  assign active_next = (state == IDLE) ? !empty : !((state == STOP) && bit_done);
  assign busy_next   = active_next || (count_next != '0);

  // Interrupt enable register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en <= wdata[0];
    end
  end

  // Level interrupt: everything queued has left the wire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && empty && !busy_next;
    end
  end
`endif

  // Combinational register read; zero outside the window
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (addr[3:2])
        REG_TXDATA:  rdata = 32'd0;
        REG_STATUS:  rdata = {28'd0, ovf, busy, full, empty};
        REG_DIVISOR: rdata = {16'd0, divisor};
`ifdef UART_TX_IRQ_EN
        REG_CTRL:    rdata = {31'd0, irq_en};
`else
        REG_CTRL:    rdata = 32'd0;
`endif
        default:     rdata = 32'd0;
      endcase
    end
  end

endmodule
